// File: rtl/ctrl_pkg.sv
// Shared definitions for the RISC control units: opcodes, ALU codes,
// controller states and trap causes.
package ctrl_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_LW   = 4'b0001;
   localparam logic [3:0] OP_SW   = 4'b0010;
   localparam logic [3:0] OP_SUBI = 4'b0011;
   localparam logic [3:0] OP_OR   = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1111;

   localparam logic [2:0] ALU_NONE = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_NOR  = 3'b011;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder shared by the multi-cycle and pipelined
// controllers. Opcodes wider than 4 bits are legal only with zero upper bits.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int ALUW = 3
) (
   input  logic [OPW-1:0]  op_i,
   output logic [ALUW-1:0] aluCtrl_o,
   output logic            aluSrc_o,
   output logic            mReg_o,
   output logic            isMem_o,
   output logic            isStore_o,
   output logic            legal_o
);

   // Full-width compares against zero-extended constants reject nonzero upper bits.
   always_comb begin
      aluCtrl_o = ALUW'(ALU_NONE);
      aluSrc_o  = 1'b0;
      mReg_o    = 1'b1;
      isMem_o   = 1'b0;
      isStore_o = 1'b0;
      legal_o   = 1'b1;
      case (op_i)
         OPW'(OP_ADD):  aluCtrl_o = ALUW'(ALU_ADD);
         OPW'(OP_LW): begin
            aluCtrl_o = ALUW'(ALU_ADD);
            aluSrc_o  = 1'b1;
            mReg_o    = 1'b0;
            isMem_o   = 1'b1;
         end
         OPW'(OP_SW): begin
            aluCtrl_o = ALUW'(ALU_ADD);
            aluSrc_o  = 1'b1;
            isMem_o   = 1'b1;
            isStore_o = 1'b1;
         end
         OPW'(OP_SUBI): begin
            aluCtrl_o = ALUW'(ALU_SUB);
            aluSrc_o  = 1'b1;
         end
         OPW'(OP_OR):   aluCtrl_o = ALUW'(ALU_OR);
         OPW'(OP_NOR):  aluCtrl_o = ALUW'(ALU_NOR);
         default: begin
            mReg_o  = 1'b0;
            legal_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller sharing one memory port,
// with illegal-opcode and memory-timeout traps and a retired counter.
module mc_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int OPW         = 4,
   parameter int ALUW        = 3,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNTW        = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OPW-1:0]  opcode,
   input  logic            mem_ready,
   output logic [ALUW-1:0] ALUctrl,
   output logic            ALUsrc,
   output logic            MReg,
   output logic            EnRW,
   output logic            MR,
   output logic            MW,
   output logic            IorD,
   output logic            IRWr,
   output logic            PCWr,
   output logic            busy,
   output logic            trap,
   output logic [1:0]      trap_cause,
   output logic [CNTW-1:0] retired
);

   localparam int WCW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   state_t          state_q;
   logic [OPW-1:0]  op_q;
   logic [WCW-1:0]  waitCnt_q;
   logic [CNTW-1:0] retired_q;
   logic [1:0]      cause_q;

   logic [OPW-1:0]  decOp;
   logic [ALUW-1:0] decAluCtrl;
   logic            decAluSrc;
   logic            decMReg;
   logic            decIsMem;
   logic            decIsStore;
   logic            decLegal;
   logic            timeoutHit;

   // In DECODE the decoder looks at the live opcode to pick EXEC or TRAP; no
   // output is driven from the decoder in that state, so outputs stay op_q-only.
   assign decOp = (state_q == ST_DECODE) ? opcode : op_q;

   ctrl_decode #(
      .OPW  (OPW),
      .ALUW (ALUW)
   ) u_decode (
      .op_i      (decOp),
      .aluCtrl_o (decAluCtrl),
      .aluSrc_o  (decAluSrc),
      .mReg_o    (decMReg),
      .isMem_o   (decIsMem),
      .isStore_o (decIsStore),
      .legal_o   (decLegal)
   );

   assign timeoutHit = (MEM_TIMEOUT > 0) && (waitCnt_q == WCW'(MEM_TIMEOUT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= '0;
         waitCnt_q <= '0;
         retired_q <= '0;
         cause_q   <= CAUSE_NONE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q   <= ST_FETCH;
               waitCnt_q <= '0;
            end
            ST_FETCH: begin
               if (mem_ready) begin
                  state_q <= ST_DECODE;
               end else if (timeoutHit) begin
                  state_q <= ST_TRAP;
                  cause_q <= CAUSE_TIMEOUT;
               end else if (MEM_TIMEOUT > 0) begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            ST_DECODE: begin
               op_q <= opcode;
               if (decLegal) begin
                  state_q <= ST_EXEC;
               end else begin
                  state_q <= ST_TRAP;
                  cause_q <= CAUSE_ILLEGAL;
               end
            end
            ST_EXEC: begin
               if (decIsMem) begin
                  state_q   <= ST_MEM;
                  waitCnt_q <= '0;
               end else begin
                  state_q <= ST_WB;
               end
            end
            ST_MEM: begin
               if (mem_ready) begin
                  if (decIsStore) begin
                     state_q   <= ST_FETCH;
                     waitCnt_q <= '0;
                     retired_q <= retired_q + 1'b1;
                  end else begin
                     state_q <= ST_WB;
                  end
               end else if (timeoutHit) begin
                  state_q <= ST_TRAP;
                  cause_q <= CAUSE_TIMEOUT;
               end else if (MEM_TIMEOUT > 0) begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            ST_WB: begin
               state_q   <= ST_FETCH;
               waitCnt_q <= '0;
               retired_q <= retired_q + 1'b1;
            end
            ST_TRAP: state_q <= ST_TRAP;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      ALUctrl = ALUW'(ALU_NONE);
      ALUsrc  = 1'b0;
      MReg    = 1'b0;
      EnRW    = 1'b0;
      MR      = 1'b0;
      MW      = 1'b0;
      IorD    = 1'b0;
      IRWr    = 1'b0;
      PCWr    = 1'b0;
      busy    = 1'b0;
      case (state_q)
         ST_FETCH: begin
            MR   = 1'b1;
            IRWr = mem_ready;
            PCWr = mem_ready;
            busy = 1'b1;
         end
         ST_DECODE: busy = 1'b1;
         ST_EXEC: begin
            ALUctrl = decAluCtrl;
            ALUsrc  = decAluSrc;
            busy    = 1'b1;
         end
         ST_MEM: begin
            ALUctrl = decAluCtrl;
            ALUsrc  = decAluSrc;
            IorD    = 1'b1;
            MR      = !decIsStore;
            MW      = decIsStore;
            busy    = 1'b1;
         end
         ST_WB: begin
            ALUctrl = decAluCtrl;
            ALUsrc  = decAluSrc;
            MReg    = decMReg;
            EnRW    = 1'b1;
            busy    = 1'b1;
         end
         default: ;
      endcase
   end

   assign trap       = (state_q == ST_TRAP);
   assign trap_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: directed per-cycle vectors push expected
// outputs, a negedge monitor pops and compares them against the DUT.
module tb_mc_ctrl_fsm;

   typedef logic [16:0] exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] opcode = 4'b0000;
   logic       mem_ready = 1'b0;
   logic [2:0] ALUctrl;
   logic       ALUsrc, MReg, EnRW, MR, MW, IorD, IRWr, PCWr, busy, trap;
   logic [1:0] trap_cause;
   logic [1:0] retired;

   exp_t  expQ[$];
   string nameQ[$];
   int    checks = 0;
   int    errors = 0;

   mc_ctrl_fsm #(
      .OPW         (4),
      .ALUW        (3),
      .MEM_TIMEOUT (3),
      .CNTW        (2)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .ALUctrl    (ALUctrl),
      .ALUsrc     (ALUsrc),
      .MReg       (MReg),
      .EnRW       (EnRW),
      .MR         (MR),
      .MW         (MW),
      .IorD       (IorD),
      .IRWr       (IRWr),
      .PCWr       (PCWr),
      .busy       (busy),
      .trap       (trap),
      .trap_cause (trap_cause),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   // Field order: ALUctrl ALUsrc MReg EnRW MR MW IorD IRWr PCWr busy trap cause retired
   function automatic exp_t mk(input logic [2:0] alu, input logic src, input logic mreg,
                               input logic enrw, input logic mr, input logic mw,
                               input logic iord, input logic irwr, input logic pcwr,
                               input logic bsy, input logic trp, input logic [1:0] cause,
                               input logic [1:0] ret);
      return {alu, src, mreg, enrw, mr, mw, iord, irwr, pcwr, bsy, trp, cause, ret};
   endfunction

   function automatic exp_t eIdle(input logic [1:0] ret);
      return mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eFetch(input logic rdy, input logic [1:0] ret);
      return mk(3'b000, 0, 0, 0, 1, 0, 0, rdy, rdy, 1, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eDecode(input logic [1:0] ret);
      return mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eExec(input logic [2:0] alu, input logic src, input logic [1:0] ret);
      return mk(alu, src, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eMemLw(input logic [1:0] ret);
      return mk(3'b010, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eMemSw(input logic [1:0] ret);
      return mk(3'b010, 1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eWb(input logic [2:0] alu, input logic src, input logic mreg,
                                input logic [1:0] ret);
      return mk(alu, src, mreg, 1, 0, 0, 0, 0, 0, 1, 0, 2'b00, ret);
   endfunction
   function automatic exp_t eTrap(input logic [1:0] cause, input logic [1:0] ret);
      return mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cause, ret);
   endfunction

   // Drive one cycle of inputs just after the rising edge and queue what the
   // DUT must show for the rest of that cycle.
   task automatic applyStimulus(input logic rstN, input logic [3:0] op, input logic rdy,
                                input exp_t e, input string nm);
      @(posedge clk);
      #1;
      rst_n     = rstN;
      opcode    = op;
      mem_ready = rdy;
      expQ.push_back(e);
      nameQ.push_back(nm);
   endtask

   task automatic checkOutput(input exp_t e, input string nm);
      exp_t act;
      act = {ALUctrl, ALUsrc, MReg, EnRW, MR, MW, IorD, IRWr, PCWr, busy, trap,
             trap_cause, retired};
      checks++;
      if (act !== e) begin
         errors++;
         $display("[TB] FAIL %s: got %b, expected %b", nm, act, e);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t  e;
         string nm;
         e  = expQ.pop_front();
         nm = nameQ.pop_front();
         checkOutput(e, nm);
      end
   end

   initial begin
      applyStimulus(0, 4'b0000, 0, eIdle(0), "reset");
      applyStimulus(1, 4'b0000, 0, eIdle(0), "idle after release");

      applyStimulus(1, 4'b0000, 1, eFetch(1, 0), "add fetch");
      applyStimulus(1, 4'b0000, 1, eDecode(0), "add decode");
      applyStimulus(1, 4'b0000, 1, eExec(3'b010, 0, 0), "add exec");
      applyStimulus(1, 4'b0000, 1, eWb(3'b010, 0, 1, 0), "add wb");

      applyStimulus(1, 4'b0001, 1, eFetch(1, 1), "lw fetch");
      applyStimulus(1, 4'b0001, 1, eDecode(1), "lw decode");
      applyStimulus(1, 4'b0001, 0, eExec(3'b010, 1, 1), "lw exec");
      applyStimulus(1, 4'b0001, 0, eMemLw(1), "lw mem wait1");
      applyStimulus(1, 4'b0001, 0, eMemLw(1), "lw mem wait2");
      applyStimulus(1, 4'b0001, 1, eMemLw(1), "lw mem ready");
      applyStimulus(1, 4'b0001, 1, eWb(3'b010, 1, 0, 1), "lw wb");

      applyStimulus(1, 4'b0010, 1, eFetch(1, 2), "sw fetch");
      applyStimulus(1, 4'b0010, 1, eDecode(2), "sw decode");
      applyStimulus(1, 4'b0010, 1, eExec(3'b010, 1, 2), "sw exec");
      applyStimulus(1, 4'b0010, 1, eMemSw(2), "sw mem");

      applyStimulus(1, 4'b0011, 1, eFetch(1, 3), "subi fetch");
      applyStimulus(1, 4'b0011, 1, eDecode(3), "subi decode");
      applyStimulus(1, 4'b0011, 1, eExec(3'b110, 1, 3), "subi exec");
      applyStimulus(1, 4'b0011, 1, eWb(3'b110, 1, 1, 3), "subi wb");

      applyStimulus(1, 4'b0111, 1, eFetch(1, 0), "or fetch wrapped");
      applyStimulus(1, 4'b0111, 1, eDecode(0), "or decode");
      applyStimulus(1, 4'b0111, 1, eExec(3'b001, 0, 0), "or exec");
      applyStimulus(1, 4'b0111, 1, eWb(3'b001, 0, 1, 0), "or wb");

      applyStimulus(1, 4'b1111, 1, eFetch(1, 1), "nor fetch");
      applyStimulus(1, 4'b1111, 1, eDecode(1), "nor decode");
      applyStimulus(1, 4'b1111, 1, eExec(3'b011, 0, 1), "nor exec");
      applyStimulus(1, 4'b1111, 1, eWb(3'b011, 0, 1, 1), "nor wb");

      for (int i = 0; i < 3; i++)
         applyStimulus(1, 4'b0000, 0, eFetch(0, 2), "fetch wait");
      applyStimulus(1, 4'b0000, 1, eFetch(1, 2), "fetch ready at limit");
      applyStimulus(1, 4'b0000, 1, eDecode(2), "late add decode");
      applyStimulus(1, 4'b0000, 1, eExec(3'b010, 0, 2), "late add exec");
      applyStimulus(1, 4'b0000, 1, eWb(3'b010, 0, 1, 2), "late add wb");

      applyStimulus(1, 4'b0010, 1, eFetch(1, 3), "sw2 fetch");
      applyStimulus(1, 4'b0010, 1, eDecode(3), "sw2 decode");
      applyStimulus(1, 4'b0010, 0, eExec(3'b010, 1, 3), "sw2 exec");
      applyStimulus(1, 4'b0010, 0, eMemSw(3), "sw2 mem waiting");
      applyStimulus(0, 4'b0010, 0, eIdle(0), "reset mid mem");
      applyStimulus(0, 4'b0000, 0, eIdle(0), "reset held");
      applyStimulus(1, 4'b0000, 0, eIdle(0), "idle after mid reset");

      for (int i = 0; i < 4; i++)
         applyStimulus(1, 4'b0000, 0, eFetch(0, 0), "fetch timeout wait");
      applyStimulus(1, 4'b0000, 1, eTrap(2'b10, 0), "timeout trap");
      applyStimulus(1, 4'b0001, 1, eTrap(2'b10, 0), "timeout trap sticky");
      applyStimulus(0, 4'b0000, 0, eIdle(0), "reset clears trap");
      applyStimulus(1, 4'b0000, 0, eIdle(0), "idle after trap reset");

      applyStimulus(1, 4'b0101, 1, eFetch(1, 0), "illegal fetch");
      applyStimulus(1, 4'b0101, 1, eDecode(0), "illegal decode");
      for (int i = 0; i < 20; i++)
         applyStimulus(1, 4'($urandom), 1'($urandom), eTrap(2'b01, 0), "illegal trap hold");

      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
